// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter: line/address widths,
// FSM state encoding and requester (owner) encoding.
package mem_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the iCache and dCache requests.
// ARB_ROUND_ROBIN_EN selects alternating grants on ties; otherwise dCache wins ties.
module arb_pick
  import mem_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t last_grant,
`endif
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid  = req_i | req_d;
    winner = OWN_I;
    if (req_i && req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_grant == OWN_I) ? OWN_D : OWN_I;
`else
      winner = OWN_D;
`endif
    end else if (req_d) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates iCache fills and dCache fills/write-backs onto one memory port,
// one transaction at a time. Macro ARB_ROUND_ROBIN_EN enables round-robin ties.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqI_mem,
  input  logic [ADDR_WIDTH-1:0] reqAddrI_mem,
  output logic                  rdyI,
  input  logic                  ackI,
  input  logic                  reqD_mem,
  input  logic                  wrD,
  input  logic [ADDR_WIDTH-1:0] reqAddrD_mem,
  input  logic [LINE_WIDTH-1:0] wdataD,
  output logic                  rdyD,
  input  logic                  ackD,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdy,
  output logic                  err
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rdy_i_q, rdy_i_d;
  logic                    rdy_d_q, rdy_d_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    pick_valid;
  owner_t                  pick_winner;
  logic                    owner_req;
  logic                    owner_ack;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t                  last_grant_q, last_grant_d;
`endif

  arb_pick u_pick (
    .req_i      (reqI_mem),
    .req_d      (reqD_mem),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign owner_req = (owner_q == OWN_D) ? reqD_mem : reqI_mem;
  assign owner_ack = (owner_q == OWN_D) ? ackD : ackI;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rdy_i_d     = rdy_i_q;
    rdy_d_d     = rdy_d_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d   = pick_winner;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_winner;
`endif
          if (pick_winner == OWN_D) begin
            mem_addr_d  = reqAddrD_mem;
            mem_wr_d    = wrD;
            mem_wdata_d = wdataD;
          end else begin
            mem_addr_d  = reqAddrI_mem;
            mem_wr_d    = 1'b0;
          end
        end
      end

      BUSY: begin
        // Completion beats timeout when both land on the same edge.
        if (mem_rdy) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          if (!mem_wr_q) rdata_d = mem_rdata;
          if (owner_req) begin
            state_d = RESP;
            rdy_i_d = (owner_q == OWN_I);
            rdy_d_d = (owner_q == OWN_D);
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (owner_ack || !owner_req) begin
          rdy_i_d = 1'b0;
          rdy_d_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rdy_i_q     <= 1'b0;
      rdy_d_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rdy_i_q     <= rdy_i_d;
      rdy_d_q     <= rdy_d_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= OWN_I;
    else       last_grant_q <= last_grant_d;
  end
`endif

  assign rdyI      = rdy_i_q;
  assign rdyD      = rdy_d_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
